// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the multiplier / product-accumulator pair.
// Keeping the default widths here keeps both stages in agreement.
package mac_pkg;

  localparam int MAC_PROD_W  = 8;
  localparam int MAC_MAX_LEN = 16;
  localparam int MAC_LEN_W   = 5;
  localparam int MAC_ACC_W   = MAC_PROD_W + $clog2(MAC_MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle of the product accumulator.
// The master drives products and consumes results; the slave is the accumulator.
interface product_accumulator_if
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int LEN_W  = MAC_LEN_W,
  parameter int ACC_W  = MAC_ACC_W
);

  logic [LEN_W-1:0]  vec_len;
  logic              in_valid;
  logic [PROD_W-1:0] in_product;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output vec_len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  vec_len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/acc_add_sat.sv
// Combinational accumulator adder: product is zero-extended, carry-out is reported.
// Build option ACC_SATURATE_EN clamps the sum to all-ones on carry; otherwise it wraps.
module acc_add_sat
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, a} + (ACC_W+1)'(b);
  assign carry = full[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further add carries again, so the clamp holds for the vector.
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products into one dot-product result per vector, with a
// stallable valid/ready result port. Adder overflow policy set by ACC_SATURATE_EN.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W  = MAC_PROD_W,
  parameter int MAX_LEN = MAC_MAX_LEN,
  parameter int LEN_W   = MAC_LEN_W,
  parameter int ACC_W   = MAC_ACC_W
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  enable,
  product_accumulator_if.slave bus
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_next;
  logic             accept;
  logic             pop;
  logic             first;
  logic             last;
  logic             ovf;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;

  // HOLD accepts a new first product only in the cycle its result is popped.
  assign bus.in_ready = enable & ((state != ST_HOLD) | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = enable & out_valid_q & bus.out_ready;
  assign first        = accept & (state != ST_ACCUM);

  assign len_clamped = (bus.vec_len == '0)                ? LEN_W'(1)       :
                       (bus.vec_len >  LEN_W'(MAX_LEN))   ? LEN_W'(MAX_LEN) :
                                                            bus.vec_len;
  assign len_eff  = first ? len_clamped : len;
  assign cnt_next = (first ? '0 : count) + LEN_W'(1);
  assign last     = (cnt_next == len_eff);
  assign add_a    = first ? '0 : acc;

  acc_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a     (add_a),
    .b     (bus.in_product),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      count       <= '0;
      len         <= LEN_W'(1);
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (enable) begin
      if (pop) out_valid_q <= 1'b0;
      if (accept) begin
        acc   <= add_sum;
        count <= cnt_next;
        ovf   <= add_carry | (ovf & ~first);
        if (first) len <= len_clamped;
        if (last) begin
          state       <= ST_HOLD;
          out_valid_q <= 1'b1;
          out_sum_q   <= add_sum;
        end else begin
          state <= ST_ACCUM;
        end
      end else if (pop) begin
        state <= ST_IDLE;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus randomized vectors
// scored against a plain-arithmetic model; a second ACC_W=9 instance exercises overflow.
module tb_product_accumulator;
  import mac_pkg::*;

  localparam int ACC_M  = MAC_ACC_W;
  localparam int ACC_W9 = 9;

  typedef struct {
    int sum;
    bit ovf;
  } result_t;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  int      n_vec = 0;
  int      n_bad = 0;
  int      n_accepts = 0;
  bit      rand_ready = 1'b0;
  result_t pops[$];

  product_accumulator_if bus ();
  product_accumulator_if #(.PROD_W(8), .LEN_W(5), .ACC_W(ACC_W9)) b9 ();

  product_accumulator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus.slave)
  );

  product_accumulator #(.ACC_W(ACC_W9)) dut9 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (b9.slave)
  );

  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    result_t r;
    if (rst_n && enable && bus.out_valid && bus.out_ready) begin
      r.sum = int'(bus.out_sum);
      r.ovf = bus.out_ovf;
      pops.push_back(r);
    end
    if (rst_n && bus.in_valid && bus.in_ready) n_accepts++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
    $fatal(1);
  end

  // Reference: the vector's sum and overflow from plain integer arithmetic.
  function automatic void model(input int prods[$], input int acc_w, output int sum, output bit ovf);
    int total = 0;
    int max_v = (1 << acc_w) - 1;
    foreach (prods[i]) total += prods[i];
    ovf = (total > max_v);
`ifdef ACC_SATURATE_EN
    sum = ovf ? max_v : total;
`else
    sum = total % (max_v + 1);
`endif
  endfunction

  function automatic int clamp_len(input int l);
    return (l == 0) ? 1 : (l > 16) ? 16 : l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_product(input int p, input int len_field, input int gap);
    int waited = 0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid   = 1'b1;
    bus.in_product = 8'(p);
    bus.vec_len    = 5'(len_field);
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vector(input int len_field, input int prods[$], input int gap_max);
    foreach (prods[i]) push_product(prods[i], len_field, (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
  endtask

  task automatic push9(input int p, input int len_field);
    int waited = 0;
    b9.in_valid   = 1'b1;
    b9.in_product = 8'(p);
    b9.vec_len    = 5'(len_field);
    @(negedge clk);
    while (!b9.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_vec++; n_bad++;
      $display("FAIL push9_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    b9.in_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int w = 0;
    while (pops.size() < n && w < 1000) begin
      tick();
      w++;
    end
    n_vec++;
    if (pops.size() < n) begin
      n_bad++;
      $display("FAIL wait_pops: got %0d results, required %0d", pops.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    bus.in_valid = 1'b0; bus.in_product = '0; bus.vec_len = '0; bus.out_ready = 1'b0;
    b9.in_valid  = 1'b0; b9.in_product  = '0; b9.vec_len  = '0; b9.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    n_vec++; if (bus.out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum: got %0d, required 0", bus.out_sum); end
    n_vec++; if (bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %b, required 0", bus.out_ovf); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    n_vec++; if (b9.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b9_out_valid: got %b, required 0", b9.out_valid); end
  endtask

  task automatic test_basic();
    int v[$]; int es; bit eo; int a0;
    pops.delete();
    bus.out_ready = 1'b1;
    v = {2, 9, 165, 28};
    model(v, ACC_M, es, eo);
    a0 = n_accepts;
    send_vector(4, v, 0);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b, required 1", bus.out_valid); end
    n_vec++; if (bus.out_sum !== ACC_M'(es)) begin n_bad++; $display("FAIL basic_sum: got %0d, required %0d", bus.out_sum, es); end
    n_vec++; if (bus.out_ovf !== eo) begin n_bad++; $display("FAIL basic_ovf: got %b, required %b", bus.out_ovf, eo); end
    n_vec++; if (n_accepts - a0 != 4) begin n_bad++; $display("FAIL basic_accepts: got %0d, required 4", n_accepts - a0); end
    tick(); tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop: got %b, required 0", bus.out_valid); end
    n_vec++; if (pops.size() != 1 || pops[0].sum != es) begin n_bad++; $display("FAIL basic_pops: got %0d results, required 1 of %0d", pops.size(), es); end
  endtask

  task automatic test_len1_stall();
    int v[$];
    pops.delete();
    bus.out_ready = 1'b0;
    v = {77};
    send_vector(1, v, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(77)) begin n_bad++; $display("FAIL len1_result: got valid=%b sum=%0d, required 1/77", bus.out_valid, bus.out_sum); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(77)) begin n_bad++; $display("FAIL len1_hold: got valid=%b sum=%0d, required 1/77", bus.out_valid, bus.out_sum); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL len1_in_ready: got %b, required 0", bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_vec++; if (pops.size() != 1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL len1_pop: got %0d pops valid=%b, required 1/0", pops.size(), bus.out_valid); end
    n_vec++; if (pops.size() == 1 && pops[0].sum != 77) begin n_bad++; $display("FAIL len1_pop_sum: got %0d, required 77", pops[0].sum); end
  endtask

  task automatic test_back_to_back();
    int v[$]; int a0;
    pops.delete();
    bus.out_ready = 1'b0;
    v = {50};
    send_vector(1, v, 0);
    a0 = n_accepts;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_product = 8'd10; bus.vec_len = 5'd2;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b, required 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got %b, required 0", bus.out_valid); end
    n_vec++; if (n_accepts - a0 != 1 || pops.size() != 1) begin n_bad++; $display("FAIL b2b_same_cycle: got %0d accepts %0d pops, required 1/1", n_accepts - a0, pops.size()); end
    push_product(20, 2, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(30)) begin n_bad++; $display("FAIL b2b_sum: got valid=%b sum=%0d, required 1/30", bus.out_valid, bus.out_sum); end
    push_product(40, 1, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(40)) begin n_bad++; $display("FAIL b2b_len1: got valid=%b sum=%0d, required 1/40", bus.out_valid, bus.out_sum); end
    tick();
    n_vec++; if (pops.size() != 3 || pops[0].sum != 50 || pops[1].sum != 30 || pops[2].sum != 40) begin n_bad++; $display("FAIL b2b_order: got %0d results, required 50,30,40", pops.size()); end
  endtask

  task automatic test_enable();
    int v[$]; int es; bit eo; int a0;
    pops.delete();
    bus.out_ready = 1'b0;
    v = {5, 6, 7};
    model(v, ACC_M, es, eo);
    push_product(5, 3, 0);
    a0 = n_accepts;
    enable = 1'b0; bus.in_valid = 1'b1; bus.in_product = 8'd6; bus.vec_len = 5'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL en_in_ready: got %b, required 0", bus.in_ready); end
      tick();
    end
    n_vec++; if (n_accepts != a0) begin n_bad++; $display("FAIL en_accepts: got %0d, required 0", n_accepts - a0); end
    enable = 1'b1;
    push_product(6, 3, 0);
    push_product(7, 3, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(es)) begin n_bad++; $display("FAIL en_sum: got valid=%b sum=%0d, required 1/%0d", bus.out_valid, bus.out_sum, es); end
    enable = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(es)) begin n_bad++; $display("FAIL en_no_pop: got valid=%b sum=%0d, required 1/%0d", bus.out_valid, bus.out_sum, es); end
    end
    enable = 1'b1;
    tick();
    n_vec++; if (pops.size() != 1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL en_pop: got %0d pops valid=%b, required 1/0", pops.size(), bus.out_valid); end
  endtask

  task automatic test_overflow();
    int v[$]; int es; bit eo;
    v = {255, 255, 10};
    model(v, ACC_W9, es, eo);
    b9.out_ready = 1'b0;
    foreach (v[i]) push9(v[i], 3);
    n_vec++; if (b9.out_valid !== 1'b1 || b9.out_sum !== ACC_W9'(es)) begin n_bad++; $display("FAIL ovf_sum: got valid=%b sum=%0d, required 1/%0d", b9.out_valid, b9.out_sum, es); end
    n_vec++; if (b9.out_ovf !== eo) begin n_bad++; $display("FAIL ovf_flag: got %b, required %b", b9.out_ovf, eo); end
    @(posedge clk); #1;
    n_vec++; if (b9.out_sum !== ACC_W9'(es) || b9.out_ovf !== eo) begin n_bad++; $display("FAIL ovf_stable: got sum=%0d ovf=%b, required %0d/%b", b9.out_sum, b9.out_ovf, es, eo); end
    b9.out_ready = 1'b1;
    push9(1, 2);
    n_vec++; if (b9.out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b, required 0", b9.out_ovf); end
    push9(2, 2);
    n_vec++; if (b9.out_sum !== ACC_W9'(3) || b9.out_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_next: got sum=%0d ovf=%b, required 3/0", b9.out_sum, b9.out_ovf); end
  endtask

  task automatic test_reset_mid();
    int v[$]; int es; bit eo;
    pops.delete();
    bus.out_ready = 1'b1;
    push_product(100, 4, 0);
    push_product(101, 4, 0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_mid_outputs: got valid=%b sum=%0d ovf=%b, required 0/0/0", bus.out_valid, bus.out_sum, bus.out_ovf); end
    n_vec++; if (b9.out_sum !== '0) begin n_bad++; $display("FAIL rst_mid_b9_sum: got %0d, required 0", b9.out_sum); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    push_product(3, 2, 0);
    push_product(4, 2, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(7)) begin n_bad++; $display("FAIL rst_mid_next: got valid=%b sum=%0d, required 1/7", bus.out_valid, bus.out_sum); end
    push_product(9, 0, 0);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(9)) begin n_bad++; $display("FAIL len0_as_1: got valid=%b sum=%0d, required 1/9", bus.out_valid, bus.out_sum); end
    for (int i = 0; i < 16; i++) v.push_back($urandom_range(0, 255));
    model(v, ACC_M, es, eo);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL len20_early: got valid=%b after 15 products, required 0", bus.out_valid); end
      end
      push_product(v[i], 20, 0);
    end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== ACC_M'(es)) begin n_bad++; $display("FAIL len20_as_16: got valid=%b sum=%0d, required 1/%0d", bus.out_valid, bus.out_sum, es); end
    wait_pops(3);
    n_vec++; if (pops.size() != 3 || pops[0].sum != 7 || pops[1].sum != 9 || pops[2].sum != es) begin n_bad++; $display("FAIL rst_mid_results: got %0d results, required 7,9,%0d", pops.size(), es); end
  endtask

  task automatic test_random();
    result_t exp_q[$];
    result_t r;
    int      lenf;
    pops.delete();
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int v[$];
      lenf = $urandom_range(0, 20);
      for (int i = 0; i < clamp_len(lenf); i++) v.push_back(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
      model(v, ACC_M, r.sum, r.ovf);
      exp_q.push_back(r);
      send_vector(lenf, v, 2);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_pops(30);
    n_vec++; if (pops.size() != 30) begin n_bad++; $display("FAIL rand_count: got %0d, required 30", pops.size()); end
    for (int i = 0; i < 30 && i < pops.size(); i++) begin
      n_vec++;
      if (pops[i].sum != exp_q[i].sum || pops[i].ovf != exp_q[i].ovf) begin
        n_bad++;
        $display("FAIL rand_vec%0d: got sum=%0d ovf=%b, required %0d/%b", i, pops[i].sum, pops[i].ovf, exp_q[i].sum, exp_q[i].ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len1_stall();
    test_back_to_back();
    test_enable();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
